bin_to_bcd_seq: RTL and testbench
=================================

Name: bin_to_bcd_seq

Overview:
Parametrised sequential binary-to-BCD converter using iterative shift-and-add-3 (double dabble), one input bit per clock. It also produces registered active-low 7-segment codes per digit, with optional leading-zero blanking. It sits between the switch/counter datapath and the HEX display drivers and replaces per-width combinational converter trees. A start/busy/done handshake lets one instance serve any W.

Parameters:
W, 10, binary input width in bits (W ≥ 2)
DIGITS, 4, number of BCD digits produced (DIGITS ≥ 1)
BLANK, 1, 1 = blank leading zero digits on seg_out; 0 = show all digits

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  synchronous active-high reset
start  input  1  request conversion; sampled only when idle
bin_in  input  W  unsigned binary operand; latched at accepted start
busy  output  1  conversion in progress
done  output  1  one-cycle pulse; bcd_out/seg_out/ovf valid and updated
ovf  output  1  value did not fit in DIGITS digits (valid with done, held)
bcd_out  output  4*DIGITS  packed BCD, digit 0 (units) in [3:0]
seg_out  output  7*DIGITS  active-low segments, digit i in [7i+6:7i], bit order {g,f,e,d,c,b,a}

Behaviour:
- Single clock, synchronous active-high reset; reset is the only initialisation.
- Reset (any cycle, including mid-conversion): state IDLE, busy=0, done=0, ovf=0, bcd_out=0, seg_out=all 1s (display dark), bit counter=0, scratch cleared. Any conversion in progress is abandoned.
- States: IDLE, SHIFT.
- IDLE with start=1 at edge k:
  - latch bin_in into shift register;
  - clear BCD scratch and ovf scratch;
  - counter=W;
  - go to SHIFT, busy=1.
- IDLE with start=0: hold all outputs.
- SHIFT, each edge:
  - every scratch digit ≥5 gets +3 (4-bit, no carry between digits);
  - then shift {scratch, binreg} left by 1, binary MSB entering digit 0 LSB;
  - if the bit shifted out of the top digit is 1, set the ovf scratch (sticky);
  - decrement the counter.
- On the edge where the counter reaches 0 (edge k+W):
  - load bcd_out from the final scratch;
  - load seg_out from the encoded digits;
  - ovf = ovf scratch;
  - done=1, busy=0, return to IDLE.
- Latency: done is high in the cycle after edge k+W, i.e. exactly W cycles after start is sampled. busy is high for exactly W cycles.
- done is high for exactly one cycle. bcd_out, seg_out and ovf hold until the next completed conversion or reset.
- start while busy=1 is ignored, not queued.
- start high in the done cycle is accepted (state is IDLE). Back-to-back conversions therefore run every W+1 cycles. start held high continuously restarts each time IDLE is reached.
- bin_in changes after acceptance have no effect.
- 7-segment encoding, active low, hex of {g..a}:
  - 0:40, 1:79, 2:24, 3:30, 4:19, 5:12, 6:02, 7:78, 8:00, 9:10;
  - codes 10–15 (reachable only on overflow) encode as 7F (blank).
- Blanking (BLANK=1): from the top digit down, each zero digit is blanked (7F) until the first nonzero digit. Digit 0 is never blanked, so value 0 displays "0". BLANK=0 shows all digits.
- When ovf=1, bcd_out holds the low DIGITS digits of the value (modulo 10^DIGITS). seg_out is formed from those digits by the same rules.
- Width rules: scratch width 4*DIGITS, shift register width W, counter width $clog2(W+1).

Test Plan:
- Reset mid-conversion: start with bin_in=10'd999, assert rst at cycle 5 → next cycle busy=0, done=0, bcd_out=0, seg_out all 1s; no done pulse follows.
- W=10, DIGITS=4, BLANK=1, bin_in=10'd1023, start 1 cycle → done exactly 10 cycles after start sampled; bcd_out=16'h1023, ovf=0, seg_out={7'h79,7'h40,7'h24,7'h30}.
- Blanking: bin_in=0 → bcd_out=0, seg_out={7F,7F,7F,40}. bin_in=7 → seg_out={7F,7F,7F,78}. Repeat with BLANK=0, bin_in=7 → {40,40,40,78}.
- Overflow: W=10, DIGITS=3, bin_in=10'd1023 → ovf=1, bcd_out=12'h023. Then bin_in=10'd999 → ovf=0, bcd_out=12'h999.
- Handshake: pulse start during busy with a different bin_in → ignored, first result unchanged. Hold start high → done every 11 cycles, busy low only in done cycles.
- Exhaustive sweep: W=10, DIGITS=4, all 0..1023 back-to-back → bcd_out matches decimal digits of the input and seg_out matches the table for every value.

Source files
------------

// File: rtl/bin_to_bcd_seq_if.sv
// Start/busy/done handshake and result bus of the sequential binary-to-BCD converter.
interface bin_to_bcd_seq_if #(
  parameter int unsigned W      = 10,
  parameter int unsigned DIGITS = 4
);
  logic                  start;
  logic [W-1:0]          bin_in;
  logic                  busy;
  logic                  done;
  logic                  ovf;
  logic [4*DIGITS-1:0]   bcd_out;
  logic [7*DIGITS-1:0]   seg_out;

  // Requester side: issues operands, watches the result.
  modport master (
    output start, bin_in,
    input  busy, done, ovf, bcd_out, seg_out
  );

  // Converter side.
  modport slave (
    input  start, bin_in,
    output busy, done, ovf, bcd_out, seg_out
  );
endinterface

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one input bit per clock,
// with registered active-low 7-segment codes and optional leading-zero blanking.
module bin_to_bcd_seq #(
  parameter int unsigned W      = 10,
  parameter int unsigned DIGITS = 4,
  parameter bit          BLANK  = 1'b1
) (
  input logic             clk,
  input logic             rst,
  bin_to_bcd_seq_if.slave bus
);

  localparam int unsigned SW = 4 * DIGITS;
  localparam int unsigned GW = 7 * DIGITS;
  localparam int unsigned CW = $clog2(W + 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    bin_q, bin_d;
  logic [SW-1:0]   scr_q, scr_d;
  logic            ovs_q, ovs_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            ovf_q, ovf_d;
  logic [SW-1:0]   bcd_q, bcd_d;
  logic [GW-1:0]   seg_q, seg_d;
  logic [SW-1:0]   adj_c;
  logic [SW-1:0]   shf_c;

  // Active-low glyph {g,f,e,d,c,b,a}; non-decimal codes go dark.
  function automatic logic [6:0] glyph(input logic [3:0] d);
    logic [6:0] g;
    case (d)
      4'd0:    g = 7'h40;
      4'd1:    g = 7'h79;
      4'd2:    g = 7'h24;
      4'd3:    g = 7'h30;
      4'd4:    g = 7'h19;
      4'd5:    g = 7'h12;
      4'd6:    g = 7'h02;
      4'd7:    g = 7'h78;
      4'd8:    g = 7'h00;
      4'd9:    g = 7'h10;
      default: g = 7'h7F;
    endcase
    return g;
  endfunction

  // Encode all digits, blanking leading zeros from the top; units always shown.
  function automatic logic [GW-1:0] encode(input logic [SW-1:0] v);
    logic [GW-1:0] r;
    logic          lead;
    logic [3:0]    d;
    int            j;
    r    = '1;
    lead = BLANK;
    for (int i = 0; i < int'(DIGITS); i++) begin
      j = int'(DIGITS) - 1 - i;
      d = v[4*j +: 4];
      if (lead && (d == 4'd0) && (j != 0)) begin
        r[7*j +: 7] = 7'h7F;
      end else begin
        r[7*j +: 7] = glyph(d);
        lead        = 1'b0;
      end
    end
    return r;
  endfunction

  // Add-3 correction on every digit >= 5, then shift the next binary bit in.
  always_comb begin
    adj_c = scr_q;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (scr_q[4*i +: 4] >= 4'd5) begin
        adj_c[4*i +: 4] = scr_q[4*i +: 4] + 4'd3;
      end
    end
    shf_c = {adj_c[SW-2:0], bin_q[W-1]};
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    scr_d   = scr_q;
    ovs_d   = ovs_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    ovf_d   = ovf_q;
    bcd_d   = bcd_q;
    seg_d   = seg_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          bin_d   = bus.bin_in;
          scr_d   = '0;
          ovs_d   = 1'b0;
          cnt_d   = CW'(W);
          busy_d  = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        scr_d = shf_c;
        bin_d = {bin_q[W-2:0], 1'b0};
        ovs_d = ovs_q | adj_c[SW-1];
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          bcd_d   = shf_c;
          seg_d   = encode(shf_c);
          ovf_d   = ovs_q | adj_c[SW-1];
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      bin_q   <= '0;
      scr_q   <= '0;
      ovs_q   <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
      bcd_q   <= '0;
      seg_q   <= '1;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      scr_q   <= scr_d;
      ovs_q   <= ovs_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
      bcd_q   <= bcd_d;
      seg_q   <= seg_d;
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.ovf     = ovf_q;
  assign bus.bcd_out = bcd_q;
  assign bus.seg_out = seg_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Bench for bin_to_bcd_seq: three instances (4 digits blanked, 3 digits blanked,
// 4 digits unblanked) driven in lockstep and checked against an arithmetic model.
module tb_bin_to_bcd_seq;

  localparam int unsigned W = 10;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] bin_in = '0;
  int           n_cmp = 0;
  int           n_err = 0;

  always #5 clk = ~clk;

  bin_to_bcd_seq_if #(.W(W), .DIGITS(4)) ia ();
  bin_to_bcd_seq_if #(.W(W), .DIGITS(3)) ib ();
  bin_to_bcd_seq_if #(.W(W), .DIGITS(4)) ic ();

  assign ia.start = start;  assign ia.bin_in = bin_in;
  assign ib.start = start;  assign ib.bin_in = bin_in;
  assign ic.start = start;  assign ic.bin_in = bin_in;

  bin_to_bcd_seq #(.W(W), .DIGITS(4), .BLANK(1'b1)) dut_a (.clk(clk), .rst(rst), .bus(ia));
  bin_to_bcd_seq #(.W(W), .DIGITS(3), .BLANK(1'b1)) dut_b (.clk(clk), .rst(rst), .bus(ib));
  bin_to_bcd_seq #(.W(W), .DIGITS(4), .BLANK(1'b0)) dut_c (.clk(clk), .rst(rst), .bus(ic));

  // ---------------- reference model ----------------
  function automatic int unsigned pow10(input int d);
    int unsigned r = 1;
    for (int i = 0; i < d; i++) r = r * 10;
    return r;
  endfunction

  function automatic logic [15:0] m_bcd(input int unsigned v, input int d);
    int unsigned m = v % pow10(d);
    logic [15:0] r = '0;
    for (int i = 0; i < d; i++) begin
      r[4*i +: 4] = 4'(m % 10);
      m = m / 10;
    end
    return r;
  endfunction

  function automatic logic [6:0] m_glyph(input int unsigned dig);
    logic [6:0] t [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    return t[dig];
  endfunction

  function automatic logic [27:0] m_seg(input int unsigned v, input int d, input bit blank);
    int unsigned m = v % pow10(d);
    int unsigned t = m;
    int nd = 0;
    logic [27:0] r = '1;
    while (t != 0) begin nd++; t = t / 10; end
    if (nd == 0) nd = 1;
    for (int i = 0; i < d; i++)
      r[7*i +: 7] = (blank && i >= nd) ? 7'h7F : m_glyph((m / pow10(i)) % 10);
    return r;
  endfunction

  function automatic logic m_ovf(input int unsigned v, input int d);
    return v >= pow10(d);
  endfunction

  // Issue one start pulse and wait (bounded) for done; lat = -1 on timeout.
  task automatic do_conv(input int unsigned v, output int lat, output int busy_cnt);
    @(posedge clk); #1; start = 1'b1; bin_in = W'(v);
    @(posedge clk); #1; start = 1'b0; bin_in = W'($urandom);
    busy_cnt = int'(ia.busy);
    lat = -1;
    for (int n = 1; n <= int'(W) + 4; n++) begin
      @(posedge clk); #1;
      busy_cnt += int'(ia.busy);
      if (ia.done) begin lat = n; break; end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; start = 1'b0;
    repeat (2) @(posedge clk); #1;
    n_cmp++; if (ia.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", ia.busy); end
    n_cmp++; if (ia.done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b expected 0", ia.done); end
    n_cmp++; if (ia.ovf !== 1'b0) begin n_err++; $display("FAIL reset_ovf: got %b expected 0", ia.ovf); end
    n_cmp++; if (ia.bcd_out !== 16'h0) begin n_err++; $display("FAIL reset_bcd: got %h expected 0", ia.bcd_out); end
    n_cmp++; if (ia.seg_out !== 28'hFFFFFFF) begin n_err++; $display("FAIL reset_seg: got %h expected fffffff", ia.seg_out); end
    rst = 1'b0;
  endtask

  task automatic test_known();
    int lat, bc;
    do_conv(1023, lat, bc);
    n_cmp++; if (lat != int'(W)) begin n_err++; $display("FAIL latency: got %0d expected %0d", lat, W); end
    n_cmp++; if (bc != int'(W)) begin n_err++; $display("FAIL busy_cycles: got %0d expected %0d", bc, W); end
    n_cmp++; if (ia.bcd_out !== 16'h1023) begin n_err++; $display("FAIL bcd_1023: got %h expected 1023", ia.bcd_out); end
    n_cmp++; if (ia.ovf !== 1'b0) begin n_err++; $display("FAIL ovf_1023: got %b expected 0", ia.ovf); end
    n_cmp++; if (ia.seg_out !== {7'h79, 7'h40, 7'h24, 7'h30}) begin n_err++; $display("FAIL seg_1023: got %h expected %h", ia.seg_out, {7'h79, 7'h40, 7'h24, 7'h30}); end
    @(posedge clk); #1;
    n_cmp++; if (ia.done !== 1'b0) begin n_err++; $display("FAIL done_one_cycle: got %b expected 0", ia.done); end
    n_cmp++; if (ia.bcd_out !== 16'h1023) begin n_err++; $display("FAIL bcd_hold: got %h expected 1023", ia.bcd_out); end
  endtask

  task automatic test_blanking();
    int lat, bc;
    do_conv(0, lat, bc);
    n_cmp++; if (ia.bcd_out !== 16'h0) begin n_err++; $display("FAIL bcd_0: got %h expected 0", ia.bcd_out); end
    n_cmp++; if (ia.seg_out !== {7'h7F, 7'h7F, 7'h7F, 7'h40}) begin n_err++; $display("FAIL seg_0_blank: got %h expected %h", ia.seg_out, {7'h7F, 7'h7F, 7'h7F, 7'h40}); end
    do_conv(7, lat, bc);
    n_cmp++; if (ia.seg_out !== {7'h7F, 7'h7F, 7'h7F, 7'h78}) begin n_err++; $display("FAIL seg_7_blank: got %h expected %h", ia.seg_out, {7'h7F, 7'h7F, 7'h7F, 7'h78}); end
    n_cmp++; if (ic.seg_out !== {7'h40, 7'h40, 7'h40, 7'h78}) begin n_err++; $display("FAIL seg_7_noblank: got %h expected %h", ic.seg_out, {7'h40, 7'h40, 7'h40, 7'h78}); end
    n_cmp++; if (ib.seg_out !== {7'h7F, 7'h7F, 7'h78}) begin n_err++; $display("FAIL seg_7_3dig: got %h expected %h", ib.seg_out, {7'h7F, 7'h7F, 7'h78}); end
  endtask

  task automatic test_overflow();
    int lat, bc;
    do_conv(1023, lat, bc);
    n_cmp++; if (ib.ovf !== 1'b1) begin n_err++; $display("FAIL ovf_set: got %b expected 1", ib.ovf); end
    n_cmp++; if (ib.bcd_out !== 12'h023) begin n_err++; $display("FAIL bcd_ovf: got %h expected 023", ib.bcd_out); end
    n_cmp++; if (ib.seg_out !== {7'h7F, 7'h24, 7'h30}) begin n_err++; $display("FAIL seg_ovf: got %h expected %h", ib.seg_out, {7'h7F, 7'h24, 7'h30}); end
    repeat (3) @(posedge clk); #1;
    n_cmp++; if (ib.ovf !== 1'b1) begin n_err++; $display("FAIL ovf_hold: got %b expected 1", ib.ovf); end
    do_conv(999, lat, bc);
    n_cmp++; if (ib.ovf !== 1'b0) begin n_err++; $display("FAIL ovf_clear: got %b expected 0", ib.ovf); end
    n_cmp++; if (ib.bcd_out !== 12'h999) begin n_err++; $display("FAIL bcd_999: got %h expected 999", ib.bcd_out); end
    n_cmp++; if (ib.seg_out !== {7'h10, 7'h10, 7'h10}) begin n_err++; $display("FAIL seg_999: got %h expected %h", ib.seg_out, {7'h10, 7'h10, 7'h10}); end
  endtask

  task automatic test_reset_mid();
    int seen = 0;
    @(posedge clk); #1; start = 1'b1; bin_in = W'(999);
    @(posedge clk); #1; start = 1'b0;
    repeat (4) @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_cmp++; if (ia.busy !== 1'b0) begin n_err++; $display("FAIL midrst_busy: got %b expected 0", ia.busy); end
    n_cmp++; if (ia.done !== 1'b0) begin n_err++; $display("FAIL midrst_done: got %b expected 0", ia.done); end
    n_cmp++; if (ia.bcd_out !== 16'h0) begin n_err++; $display("FAIL midrst_bcd: got %h expected 0", ia.bcd_out); end
    n_cmp++; if (ib.ovf !== 1'b0) begin n_err++; $display("FAIL midrst_ovf: got %b expected 0", ib.ovf); end
    n_cmp++; if (ia.seg_out !== 28'hFFFFFFF) begin n_err++; $display("FAIL midrst_seg: got %h expected fffffff", ia.seg_out); end
    repeat (W + 3) begin
      @(posedge clk); #1;
      if (ia.done || ia.busy) seen++;
    end
    n_cmp++; if (seen != 0) begin n_err++; $display("FAIL midrst_abandon: got %0d active cycles expected 0", seen); end
  endtask

  task automatic test_ignore_busy();
    int e = -1, extra = 0;
    @(posedge clk); #1; start = 1'b1; bin_in = W'(123);
    @(posedge clk); #1; start = 1'b0; bin_in = W'(5);
    repeat (3) @(posedge clk); #1;
    start = 1'b1; bin_in = W'(456);
    @(posedge clk); #1; start = 1'b0;
    for (int n = 5; n <= int'(W) + 4; n++) begin
      if (ia.done) begin e = n - 1; break; end
      @(posedge clk); #1;
    end
    n_cmp++; if (e != int'(W)) begin n_err++; $display("FAIL ignore_latency: got %0d expected %0d", e, W); end
    n_cmp++; if (ia.bcd_out !== m_bcd(123, 4)) begin n_err++; $display("FAIL ignore_bcd: got %h expected %h", ia.bcd_out, m_bcd(123, 4)); end
    repeat (W + 3) begin
      @(posedge clk); #1;
      if (ia.done || ia.busy) extra++;
    end
    n_cmp++; if (extra != 0) begin n_err++; $display("FAIL ignore_not_queued: got %0d active cycles expected 0", extra); end
  endtask

  task automatic test_random();
    int lat, bc;
    int unsigned v;
    for (int k = 0; k < 40; k++) begin
      v = $urandom_range(1023, 0);
      do_conv(v, lat, bc);
      n_cmp++; if (lat != int'(W)) begin n_err++; $display("FAIL rnd_latency v=%0d: got %0d expected %0d", v, lat, W); end
      n_cmp++; if (ia.bcd_out !== m_bcd(v, 4)) begin n_err++; $display("FAIL rnd_bcd4 v=%0d: got %h expected %h", v, ia.bcd_out, m_bcd(v, 4)); end
      n_cmp++; if (ia.seg_out !== m_seg(v, 4, 1'b1)) begin n_err++; $display("FAIL rnd_seg4 v=%0d: got %h expected %h", v, ia.seg_out, m_seg(v, 4, 1'b1)); end
      n_cmp++; if (ib.bcd_out !== 12'(m_bcd(v, 3))) begin n_err++; $display("FAIL rnd_bcd3 v=%0d: got %h expected %h", v, ib.bcd_out, 12'(m_bcd(v, 3))); end
      n_cmp++; if (ib.ovf !== m_ovf(v, 3)) begin n_err++; $display("FAIL rnd_ovf3 v=%0d: got %b expected %b", v, ib.ovf, m_ovf(v, 3)); end
      n_cmp++; if (ib.seg_out !== 21'(m_seg(v, 3, 1'b1))) begin n_err++; $display("FAIL rnd_seg3 v=%0d: got %h expected %h", v, ib.seg_out, 21'(m_seg(v, 3, 1'b1))); end
      n_cmp++; if (ic.seg_out !== m_seg(v, 4, 1'b0)) begin n_err++; $display("FAIL rnd_segnb v=%0d: got %h expected %h", v, ic.seg_out, m_seg(v, 4, 1'b0)); end
    end
  endtask

  // start held high: exhaustive sweep 0..1023, one result every W+1 cycles.
  task automatic test_back_to_back();
    int got = 0, cyc = 0, last = -1;
    @(posedge clk); #1; start = 1'b1; bin_in = W'(0);
    while (got < 1024 && cyc < 1024 * (int'(W) + 1) + 50) begin
      @(posedge clk); #1; cyc++;
      n_cmp++; if (ia.busy !== !ia.done) begin n_err++; $display("FAIL b2b_busy cyc=%0d: got busy=%b expected %b", cyc, ia.busy, !ia.done); end
      if (ia.done) begin
        if (last >= 0) begin
          n_cmp++; if (cyc - last != int'(W) + 1) begin n_err++; $display("FAIL b2b_period: got %0d expected %0d", cyc - last, W + 1); end
        end
        last = cyc;
        n_cmp++; if (ia.bcd_out !== m_bcd(got, 4) || ia.ovf !== 1'b0) begin n_err++; $display("FAIL sweep_bcd4 v=%0d: got %h expected %h", got, ia.bcd_out, m_bcd(got, 4)); end
        n_cmp++; if (ia.seg_out !== m_seg(got, 4, 1'b1)) begin n_err++; $display("FAIL sweep_seg4 v=%0d: got %h expected %h", got, ia.seg_out, m_seg(got, 4, 1'b1)); end
        n_cmp++; if (ic.seg_out !== m_seg(got, 4, 1'b0)) begin n_err++; $display("FAIL sweep_segnb v=%0d: got %h expected %h", got, ic.seg_out, m_seg(got, 4, 1'b0)); end
        n_cmp++; if (ib.bcd_out !== 12'(m_bcd(got, 3)) || ib.ovf !== m_ovf(got, 3)) begin n_err++; $display("FAIL sweep_bcd3 v=%0d: got %h/%b expected %h/%b", got, ib.bcd_out, ib.ovf, 12'(m_bcd(got, 3)), m_ovf(got, 3)); end
        n_cmp++; if (ib.seg_out !== 21'(m_seg(got, 3, 1'b1))) begin n_err++; $display("FAIL sweep_seg3 v=%0d: got %h expected %h", got, ib.seg_out, 21'(m_seg(got, 3, 1'b1))); end
        got++;
        bin_in = W'(got);
      end
    end
    start = 1'b0;
    n_cmp++; if (got != 1024) begin n_err++; $display("FAIL sweep_timeout: got %0d results expected 1024", got); end
    repeat (W + 3) @(posedge clk);
  endtask

  initial begin
    test_reset();
    test_known();
    test_blanking();
    test_overflow();
    test_reset_mid();
    test_ignore_busy();
    test_random();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
